// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 decode/execute/memory slice:
// instruction codes, ALU ops, condition codes and special register ids.
package y86_pkg;
  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;
endpackage

// File: rtl/y86_alu_cc.sv
// Execute stage: 64-bit ALU, {ZF,SF,OF} condition-code register and the
// cnd evaluation used by cmovXX / jXX.
module y86_alu_cc
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] alu_a,
  input  logic [63:0] alu_b,
  output logic [63:0] valE,
  output logic        cnd
);
  logic [3:0] alufun;
  logic       alu_of;
  logic [2:0] cc_d, cc_q;
  logic       zf, sf, of;

  always_comb begin
    alufun = (icode == I_OPQ) ? ifun : A_ADD;
    valE   = '0;
    alu_of = 1'b0;
    case (alufun)
      A_ADD: begin
        valE   = alu_b + alu_a;
        alu_of = (alu_a[63] == alu_b[63]) && (valE[63] != alu_b[63]);
      end
      A_SUB: begin
        valE   = alu_b - alu_a;
        alu_of = (alu_a[63] != alu_b[63]) && (valE[63] != alu_b[63]);
      end
      A_AND:   valE = alu_b & alu_a;
      A_XOR:   valE = alu_b ^ alu_a;
      default: ;
    endcase
  end

  // Only valid OPq updates flags; undefined ifun leaves them untouched.
  always_comb begin
    cc_d = cc_q;
    if (icode == I_OPQ && ifun <= A_XOR)
      cc_d = {valE == 64'd0, valE[63], alu_of};
  end

  always_ff @(posedge clk) begin
    if (reset) cc_q <= 3'b100;
    else       cc_q <= cc_d;
  end

  assign {zf, sf, of} = cc_q;

  always_comb begin
    cnd = 1'b0;
    if (icode == I_CMOV || icode == I_JXX) begin
      case (ifun)
        C_ALWAYS: cnd = 1'b1;
        C_LE:     cnd = (sf ^ of) | zf;
        C_L:      cnd = sf ^ of;
        C_E:      cnd = zf;
        C_NE:     cnd = ~zf;
        C_GE:     cnd = ~(sf ^ of);
        C_G:      cnd = ~(sf ^ of) & ~zf;
        default:  cnd = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/y86_dec_exe_mem.sv
// Y86-64 SEQ slice: decode register selection, execute (via y86_alu_cc)
// and a byte-addressed little-endian data memory with bounds checking.
module y86_dec_exe_mem
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [63:0] mem_address,
  input  logic [63:0] mem_data,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valE,
  output logic        cnd,
  output logic [63:0] valM,
  output logic        dmem_error
);
  localparam int AW = $clog2(MEM_BYTES);

  logic [63:0]   alu_a, alu_b;
  logic [AW-1:0] idx;
  logic [7:0]    mem_q [MEM_BYTES] = '{default: 8'h00};

  always_comb begin
    srcA  = RNONE;
    srcB  = RNONE;
    dstM  = RNONE;
    alu_a = 64'd0;
    alu_b = 64'd0;
    if (icode inside {I_CMOV, I_RMMOV, I_OPQ, I_PUSH}) srcA = rA;
    else if (icode inside {I_RET, I_POP})              srcA = RRSP;
    if (icode inside {I_RMMOV, I_MRMOV, I_OPQ})        srcB = rB;
    else if (icode inside {I_CALL, I_RET, I_PUSH, I_POP}) srcB = RRSP;
    if (icode inside {I_MRMOV, I_POP})                 dstM = rA;
    if (icode inside {I_CMOV, I_OPQ})                  alu_a = valA;
    else if (icode inside {I_IRMOV, I_RMMOV, I_MRMOV}) alu_a = valC;
    else if (icode inside {I_CALL, I_PUSH})            alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (icode inside {I_RET, I_POP})              alu_a = 64'd8;
    if (icode inside {I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP})
      alu_b = valB;
  end

  // Kept apart from decode: dstE depends on cnd, which depends on icode/ifun.
  always_comb begin
    dstE = RNONE;
    if (icode == I_CMOV)                             dstE = cnd ? rB : RNONE;
    else if (icode inside {I_IRMOV, I_OPQ})          dstE = rB;
    else if (icode inside {I_CALL, I_RET, I_PUSH, I_POP}) dstE = RRSP;
  end

  y86_alu_cc u_alu_cc (
    .clk   (clk),
    .reset (reset),
    .icode (icode),
    .ifun  (ifun),
    .alu_a (alu_a),
    .alu_b (alu_b),
    .valE  (valE),
    .cnd   (cnd)
  );

  // A non-negative address never wraps when 8 is added, so an unsigned
  // compare against the last legal word start is exact.
  assign dmem_error = (mem_read_enable | mem_write_enable) &&
                      (mem_address[63] || mem_address > 64'(MEM_BYTES - 8));
  assign idx = mem_address[AW-1:0];

  always_comb begin
    valM = 64'd0;
    if (mem_read_enable && !dmem_error)
      for (int i = 0; i < 8; i++) valM[8*i +: 8] = mem_q[idx + AW'(i)];
  end

  always_ff @(posedge clk) begin
    if (mem_write_enable && !dmem_error)
      for (int i = 0; i < 8; i++) mem_q[idx + AW'(i)] <= mem_data[8*i +: 8];
  end
endmodule

// File: tb/tb_y86_dec_exe_mem.sv
// Bench for y86_dec_exe_mem: directed scenarios plus randomized traffic
// checked against a behavioural model of decode, flags and byte memory.
module tb_y86_dec_exe_mem;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valA, valB, valC, mem_address, mem_data;
  logic        mem_read_enable, mem_write_enable;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valE, valM;
  logic        cnd, dmem_error;

  int checks = 0;
  int errors = 0;

  y86_dec_exe_mem #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valA(valA), .valB(valB), .valC(valC),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data(mem_data),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .cnd(cnd), .valM(valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic       m_zf, m_sf, m_of;
  logic [7:0] m_mem [MEM_BYTES];

  typedef struct packed {
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valE;
    logic        cnd;
    logic [63:0] valM;
    logic        err;
    logic        ld, nz, ns, no;
  } exp_t;

  function automatic logic model_cond(input logic [3:0] f);
    case (f)
      0: return 1'b1;
      1: return (m_sf != m_of) || m_zf;
      2: return m_sf != m_of;
      3: return m_zf;
      4: return !m_zf;
      5: return m_sf == m_of;
      6: return (m_sf == m_of) && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model();
    exp_t e;
    longint a, b, r, addr;
    int op;
    e = '0;
    e.srcA = (icode inside {2, 4, 6, 10}) ? rA : (icode inside {9, 11}) ? 4'h4 : 4'hF;
    e.srcB = (icode inside {4, 5, 6}) ? rB : (icode inside {8, 9, 10, 11}) ? 4'h4 : 4'hF;
    e.dstM = (icode inside {5, 11}) ? rA : 4'hF;
    a = (icode inside {2, 6}) ? valA : (icode inside {3, 4, 5}) ? valC :
        (icode inside {8, 10}) ? -8 : (icode inside {9, 11}) ? 8 : 0;
    b = (icode inside {4, 5, 6, 8, 9, 10, 11}) ? valB : 0;
    op = (icode == 6) ? int'(ifun) : 0;
    r = 0;
    e.no = 1'b0;
    case (op)
      0: begin r = b + a; e.no = (a < 0 && b < 0 && r >= 0) || (a >= 0 && b >= 0 && r < 0); end
      1: begin r = b - a; e.no = (b >= 0 && a < 0 && r < 0) || (b < 0 && a >= 0 && r >= 0); end
      2: r = b & a;
      3: r = b ^ a;
      default: r = 0;
    endcase
    e.valE = r;
    e.nz = (r == 0);
    e.ns = (r < 0);
    e.ld = (icode == 6) && (ifun <= 3);
    e.cnd = (icode == 2 || icode == 7) ? model_cond(ifun) : 1'b0;
    e.dstE = (icode == 2) ? (e.cnd ? rB : 4'hF) : (icode inside {3, 6}) ? rB :
             (icode inside {8, 9, 10, 11}) ? 4'h4 : 4'hF;
    addr = mem_address;
    e.err = (mem_read_enable || mem_write_enable) && (addr < 0 || addr + 8 > MEM_BYTES);
    if (mem_read_enable && !e.err)
      for (int i = 0; i < 8; i++) e.valM[8*i +: 8] = m_mem[int'(addr) + i];
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] ic, fn, ra, rb, input logic [63:0] va, vb, vc);
    icode = ic; ifun = fn; rA = ra; rB = rb; valA = va; valB = vb; valC = vc;
    mem_read_enable = 1'b0; mem_write_enable = 1'b0; mem_address = '0; mem_data = '0;
    #1;
  endtask

  task automatic mem_op(input logic r, w, input logic [63:0] a, d);
    icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
    mem_read_enable = r; mem_write_enable = w; mem_address = a; mem_data = d;
    #1;
  endtask

  // Advance one clock and mirror the state changes in the model.
  task automatic step();
    exp_t e;
    e = model();
    @(posedge clk);
    if (reset) {m_zf, m_sf, m_of} = 3'b100;
    else if (e.ld) {m_zf, m_sf, m_of} = {e.nz, e.ns, e.no};
    if (mem_write_enable && !e.err)
      for (int i = 0; i < 8; i++) m_mem[int'(mem_address) + i] = mem_data[8*i +: 8];
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(4'h1, 4'h0, 4'hF, 4'hF, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    drive(4'h7, 4'h3, 4'hF, 4'hF, 0, 0, 0);
    checks++; if (cnd !== 1'b1) begin errors++; $display("FAIL reset_je: got %b want 1", cnd); end
    drive(4'h7, 4'h4, 4'hF, 4'hF, 0, 0, 0);
    checks++; if (cnd !== 1'b0) begin errors++; $display("FAIL reset_jne: got %b want 0", cnd); end
    drive(4'h7, 4'h2, 4'hF, 4'hF, 0, 0, 0);
    checks++; if (cnd !== 1'b0) begin errors++; $display("FAIL reset_jl: got %b want 0", cnd); end
    checks++; if (valM !== 64'd0 || dmem_error !== 1'b0)
      begin errors++; $display("FAIL reset_mem_idle: got valM=%h err=%b want 0/0", valM, dmem_error); end
  endtask

  task automatic test_opq_sub();
    drive(4'h6, 4'h1, 4'h1, 4'h2, 64'd5, 64'd5, 0);
    checks++; if (valE !== 64'd0) begin errors++; $display("FAIL sub_valE: got %h want 0", valE); end
    checks++; if ({srcA, srcB, dstE, dstM} !== 16'h122F)
      begin errors++; $display("FAIL sub_regs: got %h want 122f", {srcA, srcB, dstE, dstM}); end
    step();
    drive(4'h7, 4'h3, 4'hF, 4'hF, 0, 0, 0);
    checks++; if (cnd !== 1'b1) begin errors++; $display("FAIL sub_je: got %b want 1", cnd); end
  endtask

  task automatic test_overflow();
    drive(4'h6, 4'h0, 4'h1, 4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    checks++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFE)
      begin errors++; $display("FAIL ovf_valE: got %h want fffffffffffffffe", valE); end
    step();
    drive(4'h7, 4'h2, 4'hF, 4'hF, 0, 0, 0);
    checks++; if (cnd !== 1'b0) begin errors++; $display("FAIL ovf_jl: got %b want 0", cnd); end
    drive(4'h7, 4'h1, 4'hF, 4'hF, 0, 0, 0);
    checks++; if (cnd !== 1'b0) begin errors++; $display("FAIL ovf_jle: got %b want 0", cnd); end
    drive(4'h7, 4'h6, 4'hF, 4'hF, 0, 0, 0);
    checks++; if (cnd !== 1'b1) begin errors++; $display("FAIL ovf_jg: got %b want 1", cnd); end
  endtask

  task automatic test_pushq();
    drive(4'hA, 4'h0, 4'h3, 4'hF, 64'h55, 64'h100, 0);
    checks++; if ({srcA, srcB, dstE, dstM} !== 16'h344F)
      begin errors++; $display("FAIL push_regs: got %h want 344f", {srcA, srcB, dstE, dstM}); end
    checks++; if (valE !== 64'hF8) begin errors++; $display("FAIL push_valE: got %h want f8", valE); end
    drive(4'hB, 4'h0, 4'h5, 4'hF, 0, 64'h100, 0);
    checks++; if ({srcA, srcB, dstE, dstM, valE} !== {16'h4445, 64'h108})
      begin errors++; $display("FAIL pop_dec: got %h/%h want 4445/108", {srcA, srcB, dstE, dstM}, valE); end
  endtask

  task automatic test_mem();
    mem_op(1'b0, 1'b1, 64'h10, 64'h1122_3344_5566_7788);
    checks++; if (dmem_error !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", dmem_error); end
    step();
    mem_op(1'b1, 1'b0, 64'h10, 0);
    checks++; if (valM !== 64'h1122_3344_5566_7788)
      begin errors++; $display("FAIL rd_word: got %h want 1122334455667788", valM); end
    checks++; if (valM[7:0] !== 8'h88) begin errors++; $display("FAIL rd_byte10: got %h want 88", valM[7:0]); end
    mem_op(1'b1, 1'b0, 64'h17, 0);
    checks++; if (valM[15:0] !== 16'h0011)
      begin errors++; $display("FAIL rd_unaligned: got %h want 0011", valM[15:0]); end
    mem_op(1'b1, 1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001);
    checks++; if (valM !== 64'h1122_3344_5566_7788)
      begin errors++; $display("FAIL rw_old: got %h want 1122334455667788", valM); end
    step();
    mem_op(1'b1, 1'b0, 64'h10, 0);
    checks++; if (valM !== 64'hDEAD_BEEF_0000_0001)
      begin errors++; $display("FAIL rw_new: got %h want deadbeef00000001", valM); end
  endtask

  task automatic test_mem_fault();
    mem_op(1'b1, 1'b0, 64'(MEM_BYTES - 4), 0);
    checks++; if (dmem_error !== 1'b1 || valM !== 64'd0)
      begin errors++; $display("FAIL fault_rd: got err=%b valM=%h want 1/0", dmem_error, valM); end
    mem_op(1'b0, 1'b1, 64'(MEM_BYTES - 4), 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (dmem_error !== 1'b1) begin errors++; $display("FAIL fault_wr: got %b want 1", dmem_error); end
    step();
    mem_op(1'b1, 1'b0, 64'(MEM_BYTES - 8), 0);
    checks++; if (dmem_error !== 1'b0 || valM !== 64'd0)
      begin errors++; $display("FAIL fault_nowrite: got err=%b valM=%h want 0/0", dmem_error, valM); end
    mem_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    checks++; if (dmem_error !== 1'b1) begin errors++; $display("FAIL fault_neg: got %b want 1", dmem_error); end
    mem_op(1'b0, 1'b0, 64'(MEM_BYTES), 0);
    checks++; if (dmem_error !== 1'b0) begin errors++; $display("FAIL fault_idle: got %b want 0", dmem_error); end
  endtask

  task automatic test_cmov();
    drive(4'h6, 4'h1, 4'h1, 4'h2, 64'd7, 64'd7, 0);
    step();
    drive(4'h2, 4'h4, 4'h1, 4'h6, 64'h1234, 64'h9999, 0);
    checks++; if (cnd !== 1'b0 || dstE !== 4'hF)
      begin errors++; $display("FAIL cmov_zf1: got cnd=%b dstE=%h want 0/f", cnd, dstE); end
    drive(4'h6, 4'h0, 4'h1, 4'h2, 64'd1, 64'd0, 0);
    step();
    drive(4'h2, 4'h4, 4'h1, 4'h6, 64'h1234, 64'h9999, 0);
    checks++; if (cnd !== 1'b1 || dstE !== 4'h6 || valE !== 64'h1234)
      begin errors++; $display("FAIL cmov_zf0: got cnd=%b dstE=%h valE=%h want 1/6/1234", cnd, dstE, valE); end
  endtask

  task automatic test_reset_midstream();
    mem_op(1'b0, 1'b1, 64'h40, 64'hCAFE_F00D_0123_4567);
    step();
    drive(4'h6, 4'h0, 4'h1, 4'h2, 64'd1, 64'd1, 0);
    step();
    drive(4'h6, 4'h0, 4'h1, 4'h2, 64'd3, 64'd4, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(4'h7, 4'h3, 4'hF, 4'hF, 0, 0, 0);
    checks++; if (cnd !== 1'b1) begin errors++; $display("FAIL midrst_cc: got %b want 1", cnd); end
    mem_op(1'b1, 1'b0, 64'h40, 0);
    checks++; if (valM !== 64'hCAFE_F00D_0123_4567)
      begin errors++; $display("FAIL midrst_mem: got %h want cafef00d01234567", valM); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [63:0] pool [4];
    for (int n = 0; n < 400; n++) begin
      pool[0] = {$urandom, $urandom};
      pool[1] = 64'($urandom_range(0, 20));
      pool[2] = 64'h8000_0000_0000_0000 - 64'($urandom_range(0, 3));
      pool[3] = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      icode = 4'($urandom_range(0, 11));
      ifun  = (icode == 4'h6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      rA = 4'($urandom); rB = 4'($urandom);
      valA = pool[$urandom_range(0, 3)];
      valB = ($urandom_range(0, 3) == 0) ? valA : pool[$urandom_range(0, 3)];
      valC = pool[$urandom_range(0, 3)];
      mem_read_enable  = ($urandom_range(0, 1) == 1);
      mem_write_enable = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0: mem_address = 64'(MEM_BYTES - 8 + int'($urandom_range(0, 12)));
        1: mem_address = {1'b1, 31'($urandom), 32'($urandom)};
        default: mem_address = 64'($urandom_range(0, MEM_BYTES - 8));
      endcase
      mem_data = {$urandom, $urandom};
      #1;
      e = model();
      checks++;
      if ({srcA, srcB, dstE, dstM, valE, cnd, valM, dmem_error} !==
          {e.srcA, e.srcB, e.dstE, e.dstM, e.valE, e.cnd, e.valM, e.err})
        begin
          errors++;
          $display("FAIL rand[%0d] ic=%h fn=%h: got regs=%h valE=%h cnd=%b valM=%h err=%b want regs=%h valE=%h cnd=%b valM=%h err=%b",
                   n, icode, ifun, {srcA, srcB, dstE, dstM}, valE, cnd, valM, dmem_error,
                   {e.srcA, e.srcB, e.dstE, e.dstM}, e.valE, e.cnd, e.valM, e.err);
        end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) m_mem[i] = 8'h00;
    {m_zf, m_sf, m_of} = 3'b100;
    test_reset();
    test_opq_sub();
    test_overflow();
    test_pushq();
    test_mem();
    test_mem_fault();
    test_cmov();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
